// File: rtl/banked_ram_pkg.sv
// Shared types and geometry helpers for the banked RAM. Combinational only; no handshake.
// The geometry constants here describe the default 16K-word, 4-bank build.
package ram_pkg;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_BANKS  = 4;
    localparam int BANK_W     = clog2(DEF_BANKS);
    localparam int OFF_W      = DEF_ADDR_W - BANK_W;
    localparam int BANK_DEPTH = 1 << OFF_W;

endpackage

// File: rtl/banked_ram_if.sv
// Request/response and clear-control bundle; requester drives master, RAM drives slave.
// req_ready stalls the requester, which must hold its request; responses cannot be stalled.
interface banked_ram_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic              rsp_valid;
    logic [WIDTH-1:0]  rsp_rdata;
    logic              clear_req;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, clear_req,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, clear_req,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/banked_ram_bank.sv
// One synchronous single-port bank with a registered, read-enabled output.
// 1-cycle read latency; no backpressure. Only the output register is reset, never the array.
module ram_bank #(
    parameter int WIDTH = 16,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) mem_q[addr] <= wdata;
    end

    // The output register only loads on a read, so the top-level response holds between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   rdata_q <= '0;
        else if (re) rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/banked_ram.sv
// Banked single-port RAM with a clear engine that zeroes all banks in parallel.
// 1-cycle read latency; req_ready is low (requests held off) for the whole clear pass.
module banked_ram
    import ram_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int ADDR_W         = 14,
    parameter int BANKS          = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    banked_ram_if.slave bus
);
    localparam int BANK_W     = clog2(BANKS);
    localparam int OFF_W      = ADDR_W - BANK_W;
    localparam int BANK_DEPTH = 1 << OFF_W;
    localparam int SEL_W      = (BANK_W > 0) ? BANK_W : 1;
    localparam int CNT_W      = (OFF_W > 0) ? OFF_W : 1;
    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] req_bank;
    logic [CNT_W-1:0] req_off;
    logic             clearing;
    logic             accept;
    logic             rd_accept;
    logic [WIDTH-1:0] bank_rdata [BANKS];

    if (BANK_W > 0) begin : g_bank_sel
        assign req_bank = bus.req_addr[ADDR_W-1 -: SEL_W];
    end else begin : g_bank_none
        assign req_bank = '0;
    end

    if (OFF_W > 0) begin : g_off_sel
        assign req_off = bus.req_addr[CNT_W-1:0];
    end else begin : g_off_none
        assign req_off = '0;
    end

    assign clearing      = (state_q == ST_CLEAR);
    assign accept        = bus.req_valid && !clearing;
    assign rd_accept     = accept && !bus.req_we;
    assign bus.req_ready = !clearing;
    assign bus.busy      = clearing;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = bank_rdata[sel_q];

    // A request accepted alongside clear_req still completes: the clear only starts next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BANK_DEPTH - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
            end
            ST_READY: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rd_accept;
            if (rd_accept) sel_q <= req_bank;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic hit;
        assign hit = (req_bank == SEL_W'(b));

        ram_bank #(
            .WIDTH (WIDTH),
            .AW    (CNT_W),
            .DEPTH (BANK_DEPTH)
        ) u_bank (
            .clock (clock),
            .reset (reset),
            .we    (clearing || (accept && bus.req_we && hit)),
            .re    (rd_accept && hit),
            .addr  (clearing ? cnt_q : req_off),
            .wdata (clearing ? {WIDTH{1'b0}} : bus.req_wdata),
            .rdata (bank_rdata[b])
        );
    end
endmodule
